axil_irq_regs: RTL and testbench

- AXI4-Lite slave register block directly downstream of the debounced interrupt pulse generators.
- Latches single-cycle `irq_pulse_in` events into sticky pending bits and masks them with a software enable register.
- Drives one level-sensitive interrupt line to the CPU.
- Software reads STATUS and clears handled bits by write-1-to-clear over AXI4-Lite.

---
 rtl/irq_regs_pkg.sv | 35 +++
 rtl/axil_irq_regs_if.sv | 39 +++
 rtl/irq_pending_bank.sv | 53 +++++
 rtl/axil_irq_regs.sv | 163 ++++++++++++++++
 tb/tb_axil_irq_regs.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_regs_pkg.sv
// irq_regs_pkg
//   Shared constants for the AXI4-Lite interrupt register block: register
//   byte offsets, the OKAY response code and the word-select decode used by
//   both the read and the write paths.
package irq_regs_pkg;

    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_ENABLE = 4'h4;
    localparam logic [3:0] REG_CLEAR  = 4'h8;
    localparam logic [3:0] REG_COUNT  = 4'hC;

    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        SEL_STATUS = 2'd0,
        SEL_ENABLE = 2'd1,
        SEL_CLEAR  = 2'd2,
        SEL_COUNT  = 2'd3
    } reg_sel_e;

    // Only address bits [3:2] select a register; everything above aliases.
    function automatic reg_sel_e decode_sel(input logic [1:0] word);
        reg_sel_e sel;
        sel = SEL_STATUS;
        case (word)
            REG_STATUS[3:2]: sel = SEL_STATUS;
            REG_ENABLE[3:2]: sel = SEL_ENABLE;
            REG_CLEAR[3:2]:  sel = SEL_CLEAR;
            REG_COUNT[3:2]:  sel = SEL_COUNT;
            default:         sel = SEL_STATUS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/axil_irq_regs_if.sv
// axil_irq_regs_if
//   AXI4-Lite bus bundle for the interrupt register block.
//   slave modport : used by axil_irq_regs (ready/resp/rdata outputs)
//   master modport: used by whatever drives the bus (CPU side / bench)
interface axil_irq_regs_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [31:0]           s_axi_wdata;
    logic [3:0]            s_axi_wstrb;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/irq_pending_bank.sv
// irq_pending_bank
//   Sticky pending bits, enable mask and the registered interrupt line.
//   Ports:
//     clk, resetn      clock, async active-low reset
//     irq_pulse_in     single-cycle event pulses (set pending, set wins)
//     en_we / clr_we   one-cycle write strobes for ENABLE / CLEAR
//     wdata, wstrb     write data (low NUM_IRQ bits) and byte strobes
//     pending, enable  current register contents
//     irq_out          registered OR of (pending & enable)
module irq_pending_bank #(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_pulse_in,
    input  logic               en_we,
    input  logic               clr_we,
    input  logic [NUM_IRQ-1:0] wdata,
    input  logic [3:0]         wstrb,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] enable,
    output logic               irq_out
);

    logic [NUM_IRQ-1:0] byte_en;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] en_mask;

    // Each bit follows the strobe of the byte lane it lives in.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_bit
        assign byte_en[i]  = wstrb[i/8];
        assign clr_mask[i] = clr_we & byte_en[i] & wdata[i];
        assign en_mask[i]  = en_we & byte_en[i];
    end

    // Lanes above NUM_IRQ carry no storage.
    logic unused_strb;
    assign unused_strb = ^wstrb;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            enable  <= '0;
            irq_out <= 1'b0;
        end else begin
            // A pulse landing in the same cycle as its clear keeps the bit set.
            pending <= (pending & ~clr_mask) | irq_pulse_in;
            enable  <= (enable & ~en_mask) | (wdata & en_mask);
            irq_out <= |(pending & enable);
        end
    end

endmodule

// File: rtl/axil_irq_regs.sv
// axil_irq_regs
//   AXI4-Lite register block that latches interrupt pulses into sticky
//   pending bits, masks them with ENABLE and drives one level interrupt.
//   Map: 0x0 STATUS (RO), 0x4 ENABLE (RW), 0x8 CLEAR (W1C), 0xC COUNT.
//   Optional: define AXIL_IRQ_COUNT_EN for a saturating 32-bit pulse counter
//   at 0xC (cleared by any strobed write); otherwise 0xC reads 0.
//   Ports:
//     clk, resetn    clock, async active-low reset
//     irq_pulse_in   NUM_IRQ single-cycle event pulses
//     irq_out        registered level interrupt to the CPU
//     s_axi          AXI4-Lite slave bus (axil_irq_regs_if.slave)
module axil_irq_regs
    import irq_regs_pkg::*;
#(
    parameter int NUM_IRQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_pulse_in,
    output logic               irq_out,
    axil_irq_regs_if.slave     s_axi
);

    // Keeps ready outputs low while reset is held and for the release edge.
    logic                  live;

    logic                  aw_held, w_held, bvalid;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [NUM_IRQ-1:0]    wdata_q;
    logic [3:0]            wstrb_q;

    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  awready, wready, arready, commit;
    reg_sel_e              wr_sel, rd_sel;

    logic [NUM_IRQ-1:0]    pending, enable;
    logic [31:0]           count_rd;

    assign awready = live & ~aw_held & ~bvalid;
    assign wready  = live & ~w_held & ~bvalid;
    assign arready = live & ~rvalid;

    // Fires exactly once per write: bvalid rises on the same edge.
    assign commit  = aw_held & w_held & ~bvalid;
    assign wr_sel  = decode_sel(awaddr_q[3:2]);
    assign rd_sel  = decode_sel(s_axi.s_axi_araddr[3:2]);

    assign s_axi.s_axi_awready = awready;
    assign s_axi.s_axi_wready  = wready;
    assign s_axi.s_axi_bvalid  = bvalid;
    assign s_axi.s_axi_bresp   = RESP_OKAY;
    assign s_axi.s_axi_arready = arready;
    assign s_axi.s_axi_rvalid  = rvalid;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = RESP_OKAY;

    logic unused_bits;
    assign unused_bits = ^{awaddr_q, s_axi.s_axi_araddr, s_axi.s_axi_wdata};

    // Write channel: AW and W park in holding registers until both arrive.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            live     <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            live <= 1'b1;
            if (s_axi.s_axi_awvalid && awready) begin
                aw_held  <= 1'b1;
                awaddr_q <= s_axi.s_axi_awaddr;
            end
            if (s_axi.s_axi_wvalid && wready) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi.s_axi_wdata[NUM_IRQ-1:0];
                wstrb_q <= s_axi.s_axi_wstrb;
            end
            if (commit)
                bvalid <= 1'b1;
            if (bvalid && s_axi.s_axi_bready) begin
                bvalid  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    irq_pending_bank #(.NUM_IRQ(NUM_IRQ)) u_bank (
        .clk          (clk),
        .resetn       (resetn),
        .irq_pulse_in (irq_pulse_in),
        .en_we        (commit && wr_sel == SEL_ENABLE),
        .clr_we       (commit && wr_sel == SEL_CLEAR),
        .wdata        (wdata_q),
        .wstrb        (wstrb_q),
        .pending      (pending),
        .enable       (enable),
        .irq_out      (irq_out)
    );

`ifdef AXIL_IRQ_COUNT_EN
    logic [31:0] count_q;
    logic [5:0]  pop;
    logic [32:0] sum;
    logic        cnt_clr;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            pop = pop + 6'(irq_pulse_in[i]);
        sum = {1'b0, count_q} + {27'd0, pop};
    end

    assign cnt_clr = commit && wr_sel == SEL_COUNT && |wstrb_q;

    // Clear beats the same-cycle increment; carry-out saturates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            count_q <= '0;
        else if (cnt_clr)
            count_q <= '0;
        else if (sum[32])
            count_q <= '1;
        else
            count_q <= sum[31:0];
    end

    assign count_rd = count_q;
`else
    assign count_rd = '0;
`endif

    always_comb begin
        rdata_d = '0;
        case (rd_sel)
            SEL_STATUS: rdata_d[NUM_IRQ-1:0] = pending;
            SEL_ENABLE: rdata_d[NUM_IRQ-1:0] = enable;
            SEL_COUNT:  rdata_d = count_rd;
            default:    rdata_d = '0;
        endcase
    end

    // Read channel: one-cycle registered response, held until rready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid  <= 1'b0;
            rdata_q <= '0;
        end else if (s_axi.s_axi_arvalid && arready) begin
            rvalid  <= 1'b1;
            rdata_q <= rdata_d;
        end else if (rvalid && s_axi.s_axi_rready) begin
            rvalid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_irq_regs.sv
// tb_axil_irq_regs
//   Directed, table-driven bench for axil_irq_regs (NUM_IRQ=4) plus
//   hand-written sequences for handshake timing and corner cases.
module tb_axil_irq_regs;

    logic       clk;
    logic       resetn;
    logic [3:0] irq_pulse_in;
    logic       irq_out;

    int checks = 0;
    int errors = 0;
    logic irq_at_b;
    logic [31:0] rd;

    axil_irq_regs_if #(.ADDR_WIDTH(4)) bus ();

    axil_irq_regs #(.NUM_IRQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .irq_pulse_in (irq_pulse_in),
        .irq_out      (irq_out),
        .s_axi        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_PULSE, OP_IRQ} op_e;
    typedef struct {
        op_e         op;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input op_e op, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.strb = s; v.exp = e;
        vecs.push_back(v);
    endtask

    // All tasks start and end on a falling edge.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_done, w_done, aw_hs, w_hs;
        int c;
        bus.s_axi_awaddr = a; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = d; bus.s_axi_wstrb = s; bus.s_axi_wvalid = 1'b1;
        bus.s_axi_bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; c = 0;
        while (!(aw_done && w_done) && c < 50) begin
            aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
            w_hs  = bus.s_axi_wvalid && bus.s_axi_wready;
            cyc(); c++;
            if (aw_hs) begin bus.s_axi_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin bus.s_axi_wvalid = 1'b0;  w_done = 1'b1;  end
        end
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        if (!(aw_done && w_done)) begin timeout("wr_aw_w"); return; end
        c = 0;
        while (!bus.s_axi_bvalid && c < 50) begin cyc(); c++; end
        if (!bus.s_axi_bvalid) begin timeout("wr_b"); return; end
        irq_at_b = irq_out;
        chk("bresp", 32'(bus.s_axi_bresp), 32'h0);
        cyc();
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int c;
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b1;
        c = 0;
        while (!bus.s_axi_arready && c < 50) begin cyc(); c++; end
        if (!bus.s_axi_arready) begin
            bus.s_axi_arvalid = 1'b0; d = 32'hDEAD_BEEF; timeout("rd_ar"); return;
        end
        cyc();
        bus.s_axi_arvalid = 1'b0;
        chk("rvalid_latency", 32'(bus.s_axi_rvalid), 32'h1);
        chk("rresp", 32'(bus.s_axi_rresp), 32'h0);
        d = bus.s_axi_rdata;
        cyc();
    endtask

    task automatic pulse(input logic [3:0] p);
        irq_pulse_in = p;
        cyc();
        irq_pulse_in = 4'b0;
    endtask

    initial begin
        resetn = 1'b0; irq_pulse_in = '0; irq_at_b = 1'b0;
        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b1; bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b1;

        // Vector table: register-map behaviour from reset onwards.
        add(OP_RD,    4'h0, 0, 0, 32'h0);
        add(OP_RD,    4'h4, 0, 0, 32'h0);
        add(OP_RD,    4'hC, 0, 0, 32'h0);
        add(OP_RD,    4'h8, 0, 0, 32'h0);
        add(OP_IRQ,   4'h0, 0, 0, 32'h0);
        add(OP_PULSE, 4'h0, 32'h2, 0, 0);
        add(OP_RD,    4'h0, 0, 0, 32'h2);
        add(OP_IRQ,   4'h0, 0, 0, 32'h0);
        add(OP_WR,    4'h4, 32'h2, 4'hF, 0);
        add(OP_IRQ,   4'h0, 0, 0, 32'h1);
        add(OP_RD,    4'h4, 0, 0, 32'h2);
        add(OP_WR,    4'h8, 32'h2, 4'hF, 0);
        add(OP_RD,    4'h0, 0, 0, 32'h0);
        add(OP_IRQ,   4'h0, 0, 0, 32'h0);
        add(OP_PULSE, 4'h0, 32'h5, 0, 0);
        add(OP_RD,    4'h0, 0, 0, 32'h5);
        add(OP_IRQ,   4'h0, 0, 0, 32'h0);
        add(OP_WR,    4'h8, 32'h4, 4'h2, 0);
        add(OP_RD,    4'h0, 0, 0, 32'h5);
        add(OP_WR,    4'h8, 32'h5, 4'h1, 0);
        add(OP_RD,    4'h0, 0, 0, 32'h0);
        add(OP_WR,    4'h0, 32'hF, 4'hF, 0);
        add(OP_RD,    4'h0, 0, 0, 32'h0);
        add(OP_WR,    4'hC, 32'hF, 4'hF, 0);
        add(OP_RD,    4'hC, 0, 0, 32'h0);
        add(OP_WR,    4'h4, 32'hFFFF_FFFF, 4'h1, 0);
        add(OP_RD,    4'h4, 0, 0, 32'hF);
        add(OP_IRQ,   4'h0, 0, 0, 32'h0);
        add(OP_WR,    4'h4, 32'h0, 4'h2, 0);
        add(OP_RD,    4'h4, 0, 0, 32'hF);
        add(OP_RD,    4'h8, 0, 0, 32'h0);
        add(OP_WR,    4'h4, 32'h0, 4'hF, 0);
        add(OP_RD,    4'h4, 0, 0, 32'h0);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(bus.s_axi_awready), 32'h0);
        chk("rst_wready",  32'(bus.s_axi_wready),  32'h0);
        chk("rst_arready", 32'(bus.s_axi_arready), 32'h0);
        chk("rst_bvalid",  32'(bus.s_axi_bvalid),  32'h0);
        chk("rst_rvalid",  32'(bus.s_axi_rvalid),  32'h0);
        chk("rst_rdata",   bus.s_axi_rdata,        32'h0);
        chk("rst_irq",     32'(irq_out),           32'h0);
        resetn = 1'b1;
        cyc();

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR:    axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                OP_PULSE: pulse(vecs[i].data[3:0]);
                OP_RD: begin
                    axi_read(vecs[i].addr, rd);
                    chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
                end
                default:  chk($sformatf("vec%0d_irq", i), 32'(irq_out), vecs[i].exp);
            endcase
        end

        // irq_out timing around enable/clear commits and pending set.
        pulse(4'b0010);
        axi_write(4'h4, 32'h2, 4'hF);
        chk("en_irq_at_commit", 32'(irq_at_b), 32'h0);
        chk("en_irq_after",     32'(irq_out),  32'h1);
        axi_write(4'h8, 32'h2, 4'hF);
        chk("clr_irq_at_commit", 32'(irq_at_b), 32'h1);
        chk("clr_irq_after",     32'(irq_out),  32'h0);
        pulse(4'b0010);
        chk("set_irq_same", 32'(irq_out), 32'h0);
        cyc();
        chk("set_irq_next", 32'(irq_out), 32'h1);

        // Pulse during the CLEAR commit cycle: set wins.
        bus.s_axi_awaddr = 4'h8; bus.s_axi_wdata = 32'h2; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_bready = 1'b1;
        cyc();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; irq_pulse_in = 4'b0010;
        cyc();
        irq_pulse_in = 4'b0;
        chk("setwin_bvalid", 32'(bus.s_axi_bvalid), 32'h1);
        cyc();
        chk("setwin_irq", 32'(irq_out), 32'h1);
        axi_read(4'h0, rd);
        chk("setwin_status", rd, 32'h2);

        // W two cycles ahead of AW, bready low for 3 cycles.
        bus.s_axi_awaddr = 4'h4; bus.s_axi_wdata = 32'h1; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_wvalid = 1'b1; bus.s_axi_bready = 1'b0;
        chk("wfirst_wready", 32'(bus.s_axi_wready), 32'h1);
        cyc();
        bus.s_axi_wvalid = 1'b0;
        chk("wfirst_wready_held", 32'(bus.s_axi_wready),  32'h0);
        chk("wfirst_awready",     32'(bus.s_axi_awready), 32'h1);
        cyc();
        bus.s_axi_awvalid = 1'b1;
        cyc();
        bus.s_axi_awvalid = 1'b0;
        chk("wfirst_awready_held", 32'(bus.s_axi_awready), 32'h0);
        chk("wfirst_no_b_yet",     32'(bus.s_axi_bvalid),  32'h0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bhold%0d_bvalid", k),  32'(bus.s_axi_bvalid),  32'h1);
            chk($sformatf("bhold%0d_awready", k), 32'(bus.s_axi_awready), 32'h0);
            chk($sformatf("bhold%0d_wready", k),  32'(bus.s_axi_wready),  32'h0);
            if (k < 2) cyc();
        end
        bus.s_axi_bready = 1'b1;
        cyc();
        chk("bdone_bvalid",  32'(bus.s_axi_bvalid),  32'h0);
        chk("bdone_awready", 32'(bus.s_axi_awready), 32'h1);
        chk("bdone_wready",  32'(bus.s_axi_wready),  32'h1);
        axi_read(4'h4, rd);
        chk("wfirst_enable", rd, 32'h1);

        // Back-to-back reads with rready low for 2 cycles.
        bus.s_axi_araddr = 4'h4; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b0;
        chk("b2b_arready0", 32'(bus.s_axi_arready), 32'h1);
        cyc();
        bus.s_axi_araddr = 4'h0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_rvalid", k),  32'(bus.s_axi_rvalid),  32'h1);
            chk($sformatf("stall%0d_rdata", k),   bus.s_axi_rdata,        32'h1);
            chk($sformatf("stall%0d_arready", k), 32'(bus.s_axi_arready), 32'h0);
            if (k < 2) cyc();
        end
        bus.s_axi_rready = 1'b1;
        cyc();
        chk("b2b_rvalid_drop", 32'(bus.s_axi_rvalid),  32'h0);
        chk("b2b_arready1",    32'(bus.s_axi_arready), 32'h1);
        cyc();
        bus.s_axi_arvalid = 1'b0;
        chk("b2b_second_rvalid", 32'(bus.s_axi_rvalid), 32'h1);
        chk("b2b_second_rdata",  bus.s_axi_rdata,       32'h2);
        cyc();

        // Reset between AW/W acceptance and commit drops the write.
        bus.s_axi_awaddr = 4'h4; bus.s_axi_wdata = 32'hF; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        cyc();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; resetn = 1'b0;
        cyc();
        chk("abort_bvalid_rst", 32'(bus.s_axi_bvalid), 32'h0);
        resetn = 1'b1;
        cyc();
        chk("abort_bvalid", 32'(bus.s_axi_bvalid),  32'h0);
        chk("abort_awready", 32'(bus.s_axi_awready), 32'h1);
        axi_read(4'h4, rd);
        chk("abort_enable", rd, 32'h0);
        axi_read(4'h0, rd);
        chk("abort_status", rd, 32'h0);

`ifdef AXIL_IRQ_COUNT_EN
        for (int k = 0; k < 5; k++) pulse(4'b0011);
        axi_read(4'hC, rd);
        chk("count_10", rd, 32'd10);
        axi_write(4'hC, 32'h0, 4'h1);
        axi_read(4'hC, rd);
        chk("count_clr", rd, 32'h0);
        force dut.count_q = 32'hFFFF_FFFE;
        #1 release dut.count_q;
        irq_pulse_in = 4'b1111;
        cyc();
        irq_pulse_in = 4'b0;
        axi_read(4'hC, rd);
        chk("count_sat", rd, 32'hFFFF_FFFF);
`else
        pulse(4'b0011);
        axi_read(4'hC, rd);
        chk("count_absent", rd, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
